// File: rtl/ecg_pkg.sv
// ecg_pkg: shared types and helpers for the ECG R-peak detector.
// Optional adaptive threshold is enabled with ECG_ADAPTIVE_THRESH_EN.
package ecg_pkg;

    localparam int ECG_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_TRACK,
        ST_REFRACT
    } state_t;

    // |v| for a w-bit two's complement value; the most negative code clamps.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] v,
                                            input int w);
        logic signed [31:0] lo;
        lo = -(32'sd1 <<< (w - 1));
        if (v == lo) return 32'(-(lo + 32'sd1));
        if (v < 0) return 32'(-v);
        return 32'(v);
    endfunction

endpackage

// File: rtl/ecg_mwi.sv
// ecg_mwi: rectifier register followed by a moving-window integrator.
// mwi_valid follows the rectified sample by one cycle.
module ecg_mwi
    import ecg_pkg::*;
#(
    parameter int DATA_W  = ECG_DATA_W,
    parameter int WIN_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    input  logic              x_valid,
    output logic [DATA_W-1:0] mwi,
    output logic              mwi_valid
);

    localparam int LW = $clog2(WIN_LEN);
    localparam int SW = DATA_W + LW;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] a_d;
    logic              a_vld_q;
    logic [DATA_W-1:0] win_q [WIN_LEN];
    logic [LW-1:0]     wp_q;
    logic [SW-1:0]     sum_q;
    logic [SW-1:0]     sum_d;
    logic              mwi_vld_q;

    assign a_d   = DATA_W'(sat_abs(32'(signed'(x)), DATA_W));
    assign sum_d = sum_q + SW'(a_q) - SW'(win_q[wp_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            a_vld_q   <= 1'b0;
            sum_q     <= '0;
            wp_q      <= '0;
            mwi_vld_q <= 1'b0;
            for (int i = 0; i < WIN_LEN; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            a_vld_q   <= x_valid;
            mwi_vld_q <= a_vld_q;
            if (x_valid) begin
                a_q <= a_d;
            end
            // Oldest entry sits at the write pointer; it leaves as a_q enters.
            if (a_vld_q) begin
                win_q[wp_q] <= a_q;
                sum_q       <= sum_d;
                wp_q        <= wp_q + LW'(1);
            end
        end
    end

    assign mwi       = sum_q[SW-1:LW];
    assign mwi_valid = mwi_vld_q;

endmodule

// File: rtl/ecg_peak_detector.sv
// ecg_peak_detector: MWI smoothing plus threshold/refractory beat FSM.
// Define ECG_ADAPTIVE_THRESH_EN to add the self-adjusting threshold level.
module ecg_peak_detector
    import ecg_pkg::*;
#(
    parameter int DATA_W  = ECG_DATA_W,
    parameter int WIN_LEN = 8,
    parameter int REFRACT = 50,
    parameter int RR_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    input  logic              x_valid,
    input  logic [DATA_W-1:0] thresh,
    output logic              peak,
    output logic [DATA_W-1:0] peak_amp,
    output logic [RR_W-1:0]   rr,
    output logic              rr_first
);

    localparam int CW = (REFRACT > 1) ? $clog2(REFRACT) : 1;

    logic [DATA_W-1:0] mwi;
    logic              mwi_valid;
    logic [DATA_W-1:0] thr_eff;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [RR_W-1:0]   rr_cnt_q, rr_cnt_d;
    logic [RR_W-1:0]   rr_inc;
    logic [CW-1:0]     ref_q, ref_d;
    logic              first_q, first_d;
    logic              peak_q, peak_d;
    logic [DATA_W-1:0] amp_q, amp_d;
    logic [RR_W-1:0]   rr_q, rr_d;
    logic              rrf_q, rrf_d;

    ecg_mwi #(
        .DATA_W  (DATA_W),
        .WIN_LEN (WIN_LEN)
    ) u_mwi (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .x_valid   (x_valid),
        .mwi       (mwi),
        .mwi_valid (mwi_valid)
    );

`ifdef ECG_ADAPTIVE_THRESH_EN
    logic [DATA_W-1:0] level_q;

    // Leaky average of beat amplitudes; settles near half the peak height.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else if (peak_d) begin
            level_q <= level_q - (level_q >> 2) + (max_q >> 3);
        end
    end

    assign thr_eff = (level_q > thresh) ? level_q : thresh;
`else
    assign thr_eff = thresh;
`endif

    assign rr_inc = (rr_cnt_q == '1) ? rr_cnt_q : rr_cnt_q + RR_W'(1);

    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        rr_cnt_d = rr_cnt_q;
        ref_d    = ref_q;
        first_d  = first_q;
        peak_d   = 1'b0;
        amp_d    = amp_q;
        rr_d     = rr_q;
        rrf_d    = rrf_q;
        if (mwi_valid) begin
            rr_cnt_d = rr_inc;
            unique case (state_q)
                ST_SEARCH: begin
                    if (mwi >= thr_eff) begin
                        state_d = ST_TRACK;
                        max_d   = mwi;
                    end
                end
                ST_TRACK: begin
                    if (mwi < thr_eff) begin
                        peak_d   = 1'b1;
                        amp_d    = max_q;
                        rr_d     = rr_inc;
                        rrf_d    = first_q;
                        rr_cnt_d = '0;
                        first_d  = 1'b0;
                        ref_d    = CW'(REFRACT - 1);
                        state_d  = ST_REFRACT;
                    end else if (mwi > max_q) begin
                        max_d = mwi;
                    end
                end
                ST_REFRACT: begin
                    if (ref_q == '0) begin
                        state_d = ST_SEARCH;
                    end else begin
                        ref_d = ref_q - CW'(1);
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SEARCH;
            max_q    <= '0;
            rr_cnt_q <= '0;
            ref_q    <= '0;
            first_q  <= 1'b1;
            peak_q   <= 1'b0;
            amp_q    <= '0;
            rr_q     <= '0;
            rrf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            max_q    <= max_d;
            rr_cnt_q <= rr_cnt_d;
            ref_q    <= ref_d;
            first_q  <= first_d;
            peak_q   <= peak_d;
            amp_q    <= amp_d;
            rr_q     <= rr_d;
            rrf_q    <= rrf_d;
        end
    end

    assign peak     = peak_q;
    assign peak_amp = amp_q;
    assign rr       = rr_q;
    assign rr_first = rrf_q;

endmodule
